// File: rtl/ifetch_unit_pkg.sv
// rtl/ifetch_unit_pkg.sv - shared constants and FSM state encoding for the fetch stage
package ifetch_unit_pkg;

  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    IF_BOOT = 3'd0,
    IF_REQ  = 3'd1,
    IF_WAIT = 3'd2,
    IF_DROP = 3'd3,
    IF_HOLD = 3'd4
  } if_state_e;

endpackage

// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - instruction fetch stage: single-outstanding imem request, registered instruction, decode handshake
// Optional misaligned-pc trap enabled by defining FETCH_MISALIGN_CHK_EN.
module ifetch_unit
  import ifetch_unit_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc,
  input  logic            redirect,
  output logic            pc_hold,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  output logic            inst_valid,
  output logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc,
  output logic            inst_fault,
  input  logic            dec_ready,
  output logic [31:0]     fetch_cnt
);

  if_state_e       state_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] inst_pc_q;
  logic [XLEN-1:0] pc_lat_q;
  logic            inst_fault_q;
  logic [31:0]     fetch_cnt_q;
  logic            fire;
  logic            misalign;

`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign = (pc[1:0] != 2'b00);
`else
  assign misalign = 1'b0;
`endif

  assign fire       = (state_q == IF_HOLD) && dec_ready;
  assign pc_hold    = !fire;
  assign imem_req   = (state_q == IF_REQ) && !misalign;
  assign imem_addr  = pc;
  assign inst_valid = (state_q == IF_HOLD);
  assign inst       = inst_q;
  assign inst_pc    = inst_pc_q;
  assign inst_fault = inst_fault_q;
  assign fetch_cnt  = fetch_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IF_BOOT;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      pc_lat_q     <= '0;
      inst_fault_q <= 1'b0;
      fetch_cnt_q  <= '0;
    end else begin
      case (state_q)
        IF_BOOT: state_q <= IF_REQ;
        IF_REQ: begin
          // A redirect with a misaligned pc refers to the stale pc, so no fault is raised.
          if (imem_req && imem_gnt) begin
            state_q  <= redirect ? IF_DROP : IF_WAIT;
            pc_lat_q <= pc;
          end else if (misalign && !redirect) begin
            state_q      <= IF_HOLD;
            inst_q       <= NOP_INST;
            inst_pc_q    <= pc;
            inst_fault_q <= 1'b1;
          end
        end
        IF_WAIT: begin
          if (imem_rvalid) begin
            if (redirect) begin
              state_q <= IF_REQ;
            end else begin
              state_q      <= IF_HOLD;
              inst_q       <= imem_rdata;
              inst_pc_q    <= pc_lat_q;
              inst_fault_q <= 1'b0;
            end
          end else if (redirect) begin
            state_q <= IF_DROP;
          end
        end
        IF_DROP: begin
          if (imem_rvalid) state_q <= IF_REQ;
        end
        IF_HOLD: begin
          if (fire) fetch_cnt_q <= fetch_cnt_q + 32'd1;
          if (fire || redirect) begin
            state_q      <= IF_REQ;
            inst_fault_q <= 1'b0;
          end
        end
        default: state_q <= IF_BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// tb/tb_ifetch_unit.sv - randomized self-checking bench for ifetch_unit with program-order reference model
module tb_ifetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        redirect = 1'b0;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic        dec_ready = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] imem_rdata = '0;
  logic        pc_hold, imem_req, inst_valid, inst_fault;
  logic [31:0] imem_addr, inst, inst_pc, fetch_cnt;

  ifetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc          (pc),
    .redirect    (redirect),
    .pc_hold     (pc_hold),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .inst_valid  (inst_valid),
    .inst        (inst),
    .inst_pc     (inst_pc),
    .inst_fault  (inst_fault),
    .dec_ready   (dec_ready),
    .fetch_cnt   (fetch_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0000_000C) return 32'h0050_0093;
    return {a[15:0] ^ 16'h5A3C, a[15:0]};
  endfunction

  // Reference: decode must see instructions in program order, where a redirect
  // restarts the stream at its target and each consumed instruction advances by 4.
  logic [31:0] pc_nx = '0;
  logic [31:0] exp_pc = '0;
  logic [31:0] exp_cnt = '0;
  bit          pend = 0;
  bit          pend_stale = 0;
  int          pend_cnt = 0;
  logic [31:0] pend_addr = '0;
  int          lat_fix = 0;
  int          cyc = 0;
  int          fire_cyc[$];

  task automatic step(input bit r, input bit rd, input logic [31:0] tgt, input bit dr, input bit gen);
    bit rv;
    bit fire;
    @(negedge clk);
    cyc++;
    pc = pc_nx;
    rv = 0;
    if (pend) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        rv   = 1;
        pend = 0;
      end
    end
    rst         = r;
    redirect    = rd;
    dec_ready   = dr;
    imem_rvalid = rv;
    imem_rdata  = rv ? mem_word(pend_addr) : $urandom;
    #1;
    imem_gnt = gen && !r && (imem_req === 1'b1);
    #1;
    fire = (inst_valid === 1'b1) && dr;
    if (!r) begin
      check("pc_hold", {31'b0, pc_hold}, {31'b0, !fire});
      check("fetch_cnt", fetch_cnt, exp_cnt);
      if (imem_req === 1'b1) begin
        check("imem_addr", imem_addr, pc);
        check("one_outstanding", {31'b0, pend && !pend_stale}, 32'd0);
      end
`ifdef FETCH_MISALIGN_CHK_EN
      if (pc[1:0] != 2'b00) check("misalign_noreq", {31'b0, imem_req}, 32'd0);
`endif
      if (fire) begin
        check("inst_pc", inst_pc, exp_pc);
`ifdef FETCH_MISALIGN_CHK_EN
        if (exp_pc[1:0] != 2'b00) begin
          check("fault_inst", inst, NOP);
          check("fault_flag", {31'b0, inst_fault}, 32'd1);
        end else begin
          check("inst", inst, mem_word(exp_pc));
          check("inst_fault", {31'b0, inst_fault}, 32'd0);
        end
`else
        check("inst", inst, mem_word(exp_pc));
        check("inst_fault", {31'b0, inst_fault}, 32'd0);
`endif
        exp_cnt++;
        fire_cyc.push_back(cyc);
      end
      if (rd) exp_pc = tgt;
      else if (fire) exp_pc = exp_pc + 32'd4;
      pc_nx = rd ? tgt : (pc_hold ? pc : pc + 32'd4);
    end else begin
      exp_cnt = '0;
      exp_pc  = '0;
      pc_nx   = '0;
      if (pend) pend_stale = 1;
    end
    if (imem_gnt) begin
      pend       = 1;
      pend_stale = 0;
      pend_addr  = imem_addr;
      pend_cnt   = (lat_fix != 0) ? lat_fix : int'($urandom_range(1, 3));
    end
  endtask

  task automatic check_boot();
    step(0, 0, 0, 1, 1);
    check("boot_req", {31'b0, imem_req}, 32'd0);
    check("boot_valid", {31'b0, inst_valid}, 32'd0);
    check("boot_inst", inst, 32'd0);
    check("boot_inst_pc", inst_pc, 32'd0);
    check("boot_fault", {31'b0, inst_fault}, 32'd0);
    check("boot_cnt", fetch_cnt, 32'd0);
    check("boot_hold", {31'b0, pc_hold}, 32'd1);
    step(0, 0, 0, 1, 0);
    check("first_req", {31'b0, imem_req}, 32'd1);
    check("first_addr", imem_addr, 32'd0);
  endtask

  initial begin
    int n;
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    check_boot();

    // Back-to-back fetches with a 1-cycle memory and an always-ready decoder.
    lat_fix = 1;
    n = 0;
    while (exp_cnt < 3 && n < 20) begin
      step(0, 0, 0, 1, 1);
      n++;
    end
    check("cadence_done", {31'b0, n < 20}, 32'd1);
    if (fire_cyc.size() >= 3) begin
      check("cadence_gap1", fire_cyc[1] - fire_cyc[0], 32'd3);
      check("cadence_gap2", fire_cyc[2] - fire_cyc[1], 32'd3);
    end
    step(0, 0, 0, 0, 1);
    check("fetch_cnt_3", fetch_cnt, 32'd3);

    // Decoder stall on the instruction at 0xC.
    n = 0;
    while (inst_valid !== 1'b1 && n < 10) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    check("stall_inst", inst, 32'h0050_0093);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0, 1);
      check("stall_stable", inst, 32'h0050_0093);
      check("stall_pc", inst_pc, 32'h0000_000C);
      check("stall_hold", {31'b0, pc_hold}, 32'd1);
    end
    step(0, 0, 0, 1, 1);
    check("fire_hold", {31'b0, pc_hold}, 32'd0);
    lat_fix = 3;
    step(0, 0, 0, 0, 1);
    check("post_fire_hold", {31'b0, pc_hold}, 32'd1);

    // Redirect while waiting for the response to 0x10.
    n = 0;
    while (imem_gnt !== 1'b1 && n < 10) begin
      step(0, 0, 0, 1, 1);
      n++;
    end
    check("wait_addr", imem_addr, 32'h0000_0010);
    step(0, 1, 32'h0000_0040, 1, 1);
    n = 0;
    do begin
      step(0, 0, 0, 1, 0);
      n++;
    end while (imem_req !== 1'b1 && n < 10);
    check("redir_addr", imem_addr, 32'h0000_0040);

    // Grant and redirect in the same request cycle.
    lat_fix = 2;
    step(0, 1, 32'h0000_0080, 1, 1);
    n = 0;
    do begin
      step(0, 0, 0, 1, 0);
      n++;
    end while (imem_req !== 1'b1 && n < 10);
    check("drop_gap", n, 32'd3);
    check("drop_addr", imem_addr, 32'h0000_0080);
    n = 0;
    while (exp_cnt < 5 && n < 20) begin
      step(0, 0, 0, 1, 1);
      n++;
    end
    check("drop_fetch_done", {31'b0, n < 20}, 32'd1);

    // Reset while a response is outstanding; it arrives after reset is released.
    lat_fix = 3;
    n = 0;
    do begin
      step(0, 0, 0, 1, 1);
      n++;
    end while (imem_gnt !== 1'b1 && n < 10);
    step(1, 0, 0, 1, 1);
    step(1, 0, 0, 1, 1);
    check_boot();

    lat_fix = 0;
    for (int i = 0; i < 3000; i++) begin
      step(0, $urandom_range(0, 9) == 0, 32'($urandom_range(0, 255)) << 2,
           $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0);
    end
    check("random_progress", {31'b0, fetch_cnt > 32'd100}, 32'd1);

`ifdef FETCH_MISALIGN_CHK_EN
    step(0, 1, 32'h0000_0006, 0, 1);
    n = 0;
    while (!(inst_valid === 1'b1 && inst_pc == 32'h6) && n < 20) begin
      step(0, 0, 0, 0, 1);
      n++;
    end
    check("mis_inst", inst, NOP);
    check("mis_fault", {31'b0, inst_fault}, 32'd1);
    check("mis_pc", inst_pc, 32'h0000_0006);
    step(0, 0, 0, 1, 1);
    step(0, 1, 32'h0000_0100, 1, 1);
    for (int i = 0; i < 20; i++) step(0, 0, 0, 1, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
Instruction fetch stage directly downstream of the PC register in the miniRV core. It takes the current pc, issues a request to instruction memory over a req/gnt + rvalid interface, and registers the returned word. It presents the instruction to decode with a valid/ready handshake and drives pc_hold back to the PC so the PC advances only when decode accepts an instruction. A redirect (taken branch or jump) aborts any in-flight fetch.

Parameters:
XLEN, 32, width of pc, address and instruction
NOP_INST, 32'h0000_0013, instruction word presented on a fault (addi x0,x0,0)

Ports:
clk  in  1  core clock
rst  in  1  synchronous active-high reset
pc  in  XLEN  current PC from the PC register
redirect  in  1  one-cycle pulse; the PC loads the branch target at this same edge
pc_hold  out  1  1 = PC must keep its value; the PC writes when (!pc_hold || redirect)
imem_req  out  1  fetch request valid
imem_addr  out  XLEN  fetch address, equal to pc while imem_req=1
imem_gnt  in  1  memory accepted the request this cycle
imem_rvalid  in  1  read data valid; at most one response per granted request, at least 1 cycle after gnt
imem_rdata  in  XLEN  read data
inst_valid  out  1  instruction available to decode
inst  out  XLEN  instruction word
inst_pc  out  XLEN  pc of inst
inst_fault  out  1  misaligned-fetch flag; tied 0 without the macro
dec_ready  in  1  decode accepts inst this cycle
fetch_cnt  out  32  count of delivered instructions

Behaviour:
- Reset (sync, clk edge with rst=1): state=BOOT; imem_req=0, inst_valid=0, inst=0, inst_pc=0, inst_fault=0, fetch_cnt=0, pc_hold=1. rst overrides all other inputs, including mid-fetch; any later rvalid for a request issued before reset is ignored because the state is not WAIT.
- FSM states: BOOT, REQ, WAIT, DROP, HOLD.
- BOOT: one bubble cycle that covers the PC's first post-reset cycle at 0. Always goes to REQ.
- REQ: imem_req=1, imem_addr=pc.
  - gnt & !redirect -> WAIT, and latch pc into the pc register.
  - gnt & redirect -> DROP (the request was for the stale pc).
  - no gnt -> stay in REQ; the address follows pc, so after a redirect the new target is fetched.
- WAIT:
  - rvalid & !redirect -> HOLD; inst<=rdata, inst_pc<=latched pc.
  - rvalid & redirect -> REQ; the data is discarded.
  - !rvalid & redirect -> DROP.
- DROP: discards exactly one response. On rvalid -> REQ. Further redirects keep the state in DROP.
- HOLD: inst_valid=1; inst and inst_pc are stable until the handshake.
  - fire = inst_valid & dec_ready -> REQ; fetch_cnt increments, wrapping at 2^32-1 to 0.
  - redirect -> REQ; if fire is also true the instruction still counts as consumed.
  - Otherwise stay in HOLD.
- inst_valid is 1 only in HOLD. It is registered; no combinational path from imem_rdata.
- pc_hold = !fire. It is 1 in every state except a HOLD cycle with dec_ready=1.
- Minimum latency with a 1-cycle memory: REQ (gnt) -> WAIT (rvalid) -> HOLD (fire), i.e. 3 cycles per instruction.
- imem_req is 0 in BOOT, WAIT, DROP and HOLD; there is never more than one outstanding request.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined: in REQ, if pc[1:0]!=0, no memory request is issued (imem_req=0). The next state is HOLD with inst=NOP_INST, inst_pc=pc and inst_fault=1. inst_fault clears when the fault instruction fires or on redirect.
- Undefined: pc[1:0] is ignored, imem_addr=pc unchanged, and inst_fault is constant 0.

Decomposition:
- Shared package/defines header holds:
  - the FSM state encoding (3-bit constants IF_BOOT, IF_REQ, IF_WAIT, IF_DROP, IF_HOLD);
  - NOP_INST and XLEN constants.
- No sub-module is required. The output register (inst, inst_pc, inst_fault) is inline.

Test Plan:
- Reset release, 1-cycle memory, dec_ready=1, pc 0,4,8: first imem_req 1 cycle after reset deasserts with addr 0. inst_valid is seen for inst_pc 0x0, 0x4, 0x8 every 3 cycles, and fetch_cnt reaches 3.
- dec_ready=0 for 5 cycles while in HOLD with inst=0x00500093: inst and inst_pc stay stable, pc_hold=1 throughout. On dec_ready=1 there is one fire and pc_hold=0 for exactly that cycle.
- redirect while in WAIT at pc=0x10, PC jumps to 0x40, rdata for 0x10 returns 2 cycles later: that data is never presented, and the next imem_addr is 0x40.
- gnt and redirect in the same REQ cycle: state goes to DROP, one response is discarded, then a request for the new pc follows.
- rst asserted in WAIT, then stale rvalid arrives: all outputs are 0 after the reset edge, the stale data is ignored, and BOOT -> REQ fetches addr 0.
- With FETCH_MISALIGN_CHK_EN, pc=0x6: no imem_req. inst_valid=1, inst=0x00000013, inst_fault=1, inst_pc=0x6.
